// File: rtl/spike_freq_expand.sv
// Spike-to-pulse-train expander: each accepted SNN spike edge becomes a burst of
// PULSES_PER_SPIKE square pulses; optional input synchronizer via SPIKE_EXPAND_SYNC_EN.
module spike_freq_expand #(
    parameter int PULSES_PER_SPIKE = 1000,
    parameter int HIGH_CYCLES      = 10,
    parameter int LOW_CYCLES       = 10,
    parameter int PENDING_MAX      = 3
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst,
    input  logic                                 i_spike,
    output logic                                 o_pulse,
    output logic                                 o_busy,
    output logic [$clog2(PENDING_MAX+1)-1:0]     o_pending,
    output logic                                 o_overflow,
    output logic [31:0]                          debug_pulse_count
);

    localparam int MAX_PH = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = $clog2(MAX_PH) + 1;
    localparam int PC_W   = $clog2(PULSES_PER_SPIKE) + 1;
    localparam int PEND_W = $clog2(PENDING_MAX + 1);

    localparam logic [PH_W-1:0]   HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0]   LOW_LAST  = PH_W'(LOW_CYCLES - 1);
    localparam logic [PC_W-1:0]   PULSE_LAST = PC_W'(PULSES_PER_SPIKE - 1);
    localparam logic [PEND_W-1:0] PEND_MAX_V = PEND_W'(PENDING_MAX);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic spike_s;

`ifdef SPIKE_EXPAND_SYNC_EN
    // Reset to 1 so a level held high across reset release never looks like an edge.
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_spike};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) sync_q <= 2'b11;
        else         sync_q <= sync_d;
    end

    assign spike_s = sync_q[1];
`else
    assign spike_s = i_spike;
`endif

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PC_W-1:0]   pulse_q, pulse_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [31:0]       dbg_q, dbg_d;
    logic              ovf_q, ovf_d;
    logic              pulse_out_q, pulse_out_d;
    logic              spike_dly_q, spike_dly_d;
    logic              spike_edge;
    logic              consumed;

    assign spike_edge  = spike_s & ~spike_dly_q;
    assign spike_dly_d = spike_s;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        pulse_d  = pulse_q;
        pend_d   = pend_q;
        dbg_d    = dbg_q;
        ovf_d    = 1'b0;
        consumed = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                pulse_d = '0;
                if (spike_edge) begin
                    state_d  = HIGH;
                    dbg_d    = '0;
                    consumed = 1'b1;
                end
            end
            HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    dbg_d   = dbg_q + 32'd1;
                    if (pulse_q != PULSE_LAST) begin
                        state_d = HIGH;
                        pulse_d = pulse_q + 1'b1;
                    end else if (spike_edge) begin
                        // A same-cycle edge feeds the next burst directly, bypassing the queue.
                        state_d  = HIGH;
                        pulse_d  = '0;
                        dbg_d    = '0;
                        consumed = 1'b1;
                    end else if (pend_q != '0) begin
                        state_d = HIGH;
                        pulse_d = '0;
                        dbg_d   = '0;
                        pend_d  = pend_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                        pulse_d = '0;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (spike_edge && !consumed) begin
            if (pend_q < PEND_MAX_V) pend_d = pend_q + 1'b1;
            else                     ovf_d  = 1'b1;
        end

        pulse_out_d = (state_d == HIGH);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            pulse_q     <= '0;
            pend_q      <= '0;
            dbg_q       <= '0;
            ovf_q       <= 1'b0;
            pulse_out_q <= 1'b0;
            spike_dly_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_q     <= pulse_d;
            pend_q      <= pend_d;
            dbg_q       <= dbg_d;
            ovf_q       <= ovf_d;
            pulse_out_q <= pulse_out_d;
            spike_dly_q <= spike_dly_d;
        end
    end

    assign o_pulse           = pulse_out_q;
    assign o_busy            = (state_q != IDLE);
    assign o_pending         = pend_q;
    assign o_overflow        = ovf_q;
    assign debug_pulse_count = dbg_q;

endmodule

// File: tb/tb_spike_freq_expand.sv
// Directed bench for spike_freq_expand with PULSES_PER_SPIKE=4, HIGH=2, LOW=3, PENDING_MAX=3.
module tb_spike_freq_expand;

    localparam int P = 4;
    localparam int H = 2;
    localparam int L = 3;
    localparam int PM = 3;
    localparam int BURST = P * (H + L);
`ifdef SPIKE_EXPAND_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NSTEP = 200;
    localparam int NTBL = 26;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        i_spike = 1'b0;
    logic        o_pulse;
    logic        o_busy;
    logic [1:0]  o_pending;
    logic        o_overflow;
    logic [31:0] debug_pulse_count;

    int n_tests = 0;
    int n_fail = 0;

    spike_freq_expand #(
        .PULSES_PER_SPIKE(P), .HIGH_CYCLES(H), .LOW_CYCLES(L), .PENDING_MAX(PM)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_spike(i_spike),
        .o_pulse(o_pulse), .o_busy(o_busy), .o_pending(o_pending),
        .o_overflow(o_overflow), .debug_pulse_count(debug_pulse_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       spk;
        logic       pulse;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
        int         dbg;
    } vec_t;

    vec_t tbl[NTBL];

    logic sched[NSTEP];
    int   ob_pulse[NSTEP];
    int   ob_busy[NSTEP];
    int   ob_pend[NSTEP];
    int   ob_ovf[NSTEP];
    int   ob_dbg[NSTEP];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < NSTEP; i++) sched[i] = 1'b0;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            i_spike = sched[t];
            @(posedge sys_clk);
            @(negedge sys_clk);
            ob_pulse[t] = int'(o_pulse);
            ob_busy[t]  = int'(o_busy);
            ob_pend[t]  = int'(o_pending);
            ob_ovf[t]   = int'(o_overflow);
            ob_dbg[t]   = int'(debug_pulse_count);
        end
    endtask

    task automatic do_reset(input logic spk);
        @(negedge sys_clk);
        i_spike = spk;
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += ob_busy[i];
        return c;
    endfunction

    initial begin
        // Scenario 1 table: one 5-cycle spike from IDLE.
        for (int t = 0; t < NTBL; t++) begin
            int u;
            logic in_b;
            u = t - LAT;
            in_b = (u >= 0) && (u < BURST);
            tbl[t].spk   = (t < 5);
            tbl[t].busy  = in_b;
            tbl[t].pulse = in_b && ((u % (H + L)) < H);
            tbl[t].pend  = 2'd0;
            tbl[t].ovf   = 1'b0;
            tbl[t].dbg   = (u < 0) ? 0 : ((u < BURST) ? u / (H + L) : P);
        end

        sys_rst = 1'b1;
        i_spike = 1'b0;
        #12;
        chk("reset_pulse", int'(o_pulse), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_pending", int'(o_pending), 0);
        chk("reset_ovf", int'(o_overflow), 0);
        chk("reset_dbg", int'(debug_pulse_count), 0);
        do_reset(1'b0);

        for (int t = 0; t < NTBL; t++) begin
            i_spike = tbl[t].spk;
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk($sformatf("s1_pulse[%0d]", t), int'(o_pulse), int'(tbl[t].pulse));
            chk($sformatf("s1_busy[%0d]", t), int'(o_busy), int'(tbl[t].busy));
            chk($sformatf("s1_pend[%0d]", t), int'(o_pending), int'(tbl[t].pend));
            chk($sformatf("s1_ovf[%0d]", t), int'(o_overflow), int'(tbl[t].ovf));
            chk($sformatf("s1_dbg[%0d]", t), int'(debug_pulse_count), tbl[t].dbg);
        end

        // Scenario 2: second spike edge at burst cycle 7.
        do_reset(1'b0);
        clear_sched();
        sched[0] = 1'b1; sched[1] = 1'b1; sched[7] = 1'b1; sched[8] = 1'b1;
        run(50);
        chk("s2_pend_before", ob_pend[6 + LAT], 0);
        chk("s2_pend_set", ob_pend[7 + LAT], 1);
        chk("s2_pend_hold", ob_pend[19 + LAT], 1);
        chk("s2_pend_drain", ob_pend[20 + LAT], 0);
        chk("s2_pulse_nogap", ob_pulse[20 + LAT], 1);
        chk("s2_dbg_restart", ob_dbg[20 + LAT], 0);
        chk("s2_busy_total", count_busy(50), 2 * BURST);
        chk("s2_busy_end", ob_busy[39 + LAT], 1);
        chk("s2_idle_after", ob_busy[40 + LAT], 0);
        chk("s2_dbg_final", ob_dbg[40 + LAT], P);

        // Scenario 3: first spike plus 5 more during the burst.
        do_reset(1'b0);
        clear_sched();
        for (int k = 0; k < 6; k++) sched[2 * k] = 1'b1;
        run(100);
        chk("s3_pend_sat", ob_pend[6 + LAT], PM);
        chk("s3_ovf_4th", ob_ovf[8 + LAT], 1);
        chk("s3_ovf_4th_clr", ob_ovf[9 + LAT], 0);
        chk("s3_ovf_5th", ob_ovf[10 + LAT], 1);
        chk("s3_ovf_5th_clr", ob_ovf[11 + LAT], 0);
        begin
            int c = 0;
            for (int i = 0; i < 100; i++) c += ob_ovf[i];
            chk("s3_ovf_count", c, 2);
        end
        chk("s3_pend_dec", ob_pend[20 + LAT], 2);
        chk("s3_busy_total", count_busy(100), 4 * BURST);
        chk("s3_idle_after", ob_busy[80 + LAT], 0);

        // Scenario 4: edge arrives in the final LOW cycle of the burst.
        do_reset(1'b0);
        clear_sched();
        for (int i = 0; i < 5; i++) sched[i] = 1'b1;
        for (int i = 20; i < 25; i++) sched[i] = 1'b1;
        run(50);
        chk("s4_pulse_nogap", ob_pulse[20 + LAT], 1);
        chk("s4_low_before", ob_pulse[19 + LAT], 0);
        begin
            int c = 0;
            for (int i = 0; i < 50; i++) c += ob_pend[i];
            chk("s4_pend_zero", c, 0);
        end
        chk("s4_busy_total", count_busy(50), 2 * BURST);
        chk("s4_idle_after", ob_busy[40 + LAT], 0);

        // Scenario 5: spike held high across reset release.
        do_reset(1'b1);
        clear_sched();
        for (int i = 0; i < 10; i++) sched[i] = 1'b1;
        for (int i = 11; i < 16; i++) sched[i] = 1'b1;
        run(20);
        chk("s5_no_burst", count_busy(10), 0);
        chk("s5_start", ob_pulse[11 + LAT], 1);
        chk("s5_start_busy", ob_busy[11 + LAT], 1);

        // Scenario 6: async reset mid-HIGH with two queued spikes.
        do_reset(1'b0);
        clear_sched();
        sched[0] = 1'b1; sched[2] = 1'b1; sched[4] = 1'b1;
        run(6 + LAT);
        chk("s6_pend_pre", ob_pend[5 + LAT], 2);
        chk("s6_high_pre", ob_pulse[5 + LAT], 1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("s6_async_pulse", int'(o_pulse), 0);
        chk("s6_async_busy", int'(o_busy), 0);
        chk("s6_async_pend", int'(o_pending), 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        clear_sched();
        run(40);
        chk("s6_no_burst", count_busy(40), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
